// File: rtl/regfile_32x64_if.sv
// rtl/regfile_32x64_if.sv - read, write and scoreboard bundle of the integer register file
interface regfile_32x64_if #(
    parameter int N = 64
);
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [N-1:0] rdata1;
    logic [N-1:0] rdata2;
    logic         busy1;
    logic         busy2;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [N-1:0] wr_data;
    logic         pend_set;
    logic [4:0]   pend_addr;

    modport master (
        output rs1, rs2, wr_en, wr_addr, wr_data, pend_set, pend_addr,
        input  rdata1, rdata2, busy1, busy2
    );

    modport slave (
        input  rs1, rs2, wr_en, wr_addr, wr_data, pend_set, pend_addr,
        output rdata1, rdata2, busy1, busy2
    );
endinterface

// File: rtl/regfile_32x64.sv
// rtl/regfile_32x64.sv - 32 x N register file with XZR, pending-write scoreboard; optional REGFILE_BYPASS_EN
module regfile_32x64 #(
    parameter int N        = 64,
    parameter int ZERO_REG = 31
) (
    input  logic            clk,
    input  logic            reset,
    regfile_32x64_if.slave  rf
);
    localparam logic [4:0] ZR = 5'(ZERO_REG);

    logic [N-1:0] regs_q [32];
    logic [31:0]  busy_q;
    logic [31:0]  busy_d;
    logic [N-1:0] mux_in [32];
    logic [31:0]  busy_vis;

    // Clear first, then set, so a new producer supersedes the retiring one.
    always_comb begin
        busy_d = busy_q;
        if (rf.wr_en)
            busy_d[rf.wr_addr] = 1'b0;
        if (rf.pend_set)
            busy_d[rf.pend_addr] = 1'b1;
        busy_d[ZR] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                regs_q[i] <= '0;
            busy_q <= '0;
        end else begin
            if (rf.wr_en && rf.wr_addr != ZR)
                regs_q[rf.wr_addr] <= rf.wr_data;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 32; i++)
            mux_in[i] = (i == ZERO_REG) ? '0 : regs_q[i];
        busy_vis     = busy_q;
        busy_vis[ZR] = 1'b0;
    end

    logic [N-1:0] rd1_stored;
    logic [N-1:0] rd2_stored;
    logic         bz1_stored;
    logic         bz2_stored;
    logic [N-1:0] rd1_sel;
    logic [N-1:0] rd2_sel;
    logic         bz1_sel;
    logic         bz2_sel;

    assign rd1_stored = mux_in[rf.rs1];
    assign rd2_stored = mux_in[rf.rs2];
    assign bz1_stored = busy_vis[rf.rs1];
    assign bz2_stored = busy_vis[rf.rs2];

`ifdef REGFILE_BYPASS_EN
    logic hit1;
    logic hit2;

    assign hit1 = rf.wr_en && (rf.wr_addr == rf.rs1) && (rf.rs1 != ZR);
    assign hit2 = rf.wr_en && (rf.wr_addr == rf.rs2) && (rf.rs2 != ZR);

    // A retiring write unblocks the reader unless a new producer claims the same register.
    always_comb begin
        rd1_sel = hit1 ? rf.wr_data : rd1_stored;
        rd2_sel = hit2 ? rf.wr_data : rd2_stored;
        bz1_sel = bz1_stored;
        bz2_sel = bz2_stored;
        if (hit1 && !(rf.pend_set && rf.pend_addr == rf.rs1))
            bz1_sel = 1'b0;
        if (hit2 && !(rf.pend_set && rf.pend_addr == rf.rs2))
            bz2_sel = 1'b0;
    end
`else
    always_comb begin
        rd1_sel = rd1_stored;
        rd2_sel = rd2_stored;
        bz1_sel = bz1_stored;
        bz2_sel = bz2_stored;
    end
`endif

    assign rf.rdata1 = reset ? '0 : rd1_sel;
    assign rf.rdata2 = reset ? '0 : rd2_sel;
    assign rf.busy1  = reset ? 1'b0 : bz1_sel;
    assign rf.busy2  = reset ? 1'b0 : bz2_sel;
endmodule

// File: tb/tb_regfile_32x64.sv
// tb/tb_regfile_32x64.sv - randomized self-checking bench for regfile_32x64 against an array model
module tb_regfile_32x64;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic [63:0] m_reg  [32];
    logic        m_busy [32];

    regfile_32x64_if #(.N(64)) bus ();

    regfile_32x64 #(.N(64), .ZERO_REG(31)) dut (
        .clk   (clk),
        .reset (reset),
        .rf    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_rdata(input logic [4:0] a);
        if (reset || a == 5'd31)
            return 64'd0;
`ifdef REGFILE_BYPASS_EN
        if (bus.wr_en && bus.wr_addr == a)
            return bus.wr_data;
`endif
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (reset || a == 5'd31)
            return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (bus.wr_en && bus.wr_addr == a)
            return (bus.pend_set && bus.pend_addr == a) ? m_busy[a] : 1'b0;
`endif
        return m_busy[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 64'd0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                         input logic ps, input logic [4:0] pa,
                         input logic [4:0] a1, input logic [4:0] a2);
        bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
        bus.pend_set = ps; bus.pend_addr = pa;
        bus.rs1 = a1; bus.rs2 = a2;
    endtask

    // One clock: drive after the falling edge, check before the rising edge, then advance the model.
    task automatic cycle(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                         input logic ps, input logic [4:0] pa,
                         input logic [4:0] a1, input logic [4:0] a2);
        drive(we, wa, wd, ps, pa, a1, a2);
        #1;
        chk("rdata1", bus.rdata1, exp_rdata(a1));
        chk("rdata2", bus.rdata2, exp_rdata(a2));
        chk("busy1", {63'd0, bus.busy1}, {63'd0, exp_busy(a1)});
        chk("busy2", {63'd0, bus.busy2}, {63'd0, exp_busy(a2)});
        @(posedge clk);
        if (!reset) begin
            if (we && wa != 5'd31) m_reg[wa] = wd;
            if (we) m_busy[wa] = 1'b0;
            if (ps) m_busy[pa] = 1'b1;
            m_busy[31] = 1'b0;
        end
        @(negedge clk);
    endtask

    function automatic logic [4:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 9) return 5'd31;
        if (r == 8) return 5'($urandom_range(0, 31));
        return 5'(r);
    endfunction

    initial begin
        reset = 1'b1;
        model_clear();
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);

        // Reset-state reads while reset is held, with write traffic that must be ignored
        for (int a = 0; a < 32; a++)
            cycle(1'b1, 5'(a), {$urandom, $urandom}, 1'b1, 5'(a), 5'(a), 5'(31 - a));
        reset = 1'b0;
        cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd5, 5'd7);

        // Write/readback of reg 5
        drive(1'b1, 5'd5, 64'hDEADBEEFCAFEF00D, 1'b0, 5'd0, 5'd5, 5'd5);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("wr5_cycle_t", bus.rdata1, 64'hDEADBEEFCAFEF00D);
`else
        chk("wr5_cycle_t", bus.rdata1, 64'd0);
`endif
        cycle(1'b1, 5'd5, 64'hDEADBEEFCAFEF00D, 1'b0, 5'd0, 5'd5, 5'd5);
        cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd5, 5'd5);
        chk("wr5_after", bus.rdata1, 64'hDEADBEEFCAFEF00D);

        // XZR: write and pend on 31
        cycle(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd31, 5'd31, 5'd31);
        cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd31, 5'd31);
        chk("xzr_data", bus.rdata2, 64'd0);
        chk("xzr_busy", {63'd0, bus.busy2}, 64'd0);

        // Scoreboard on reg 7
        cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 5'd7, 5'd3);
        chk("sb7_set", {63'd0, bus.busy1}, 64'd1);
        cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd7, 5'd7);
        cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd7, 5'd7);
        cycle(1'b1, 5'd7, 64'h42, 1'b0, 5'd0, 5'd7, 5'd1);
        chk("sb7_clr", {63'd0, bus.busy1}, 64'd0);
        chk("sb7_data", bus.rdata1, 64'h42);

        // Set/clear collision on reg 9
        cycle(1'b1, 5'd9, 64'h9999_0000_1111_2222, 1'b1, 5'd9, 5'd9, 5'd2);
        cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd9, 5'd9);
        chk("coll9_busy", {63'd0, bus.busy1}, 64'd1);
        chk("coll9_data", bus.rdata1, 64'h9999_0000_1111_2222);

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            logic [4:0] wa, pa, a1, a2;
            wa = rand_addr();
            pa = ($urandom_range(0, 3) == 0) ? wa : rand_addr();
            a1 = ($urandom_range(0, 3) == 0) ? wa : rand_addr();
            a2 = ($urandom_range(0, 4) == 0) ? a1 : rand_addr();
            cycle(1'($urandom), wa, {$urandom, $urandom}, 1'($urandom), pa, a1, a2);
        end

        // Mid-operation asynchronous reset
        drive(1'b1, 5'd3, 64'h1234, 1'b1, 5'd3, 5'd3, 5'd5);
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        chk("mid_rst_rd1", bus.rdata1, 64'd0);
        chk("mid_rst_rd2", bus.rdata2, 64'd0);
        chk("mid_rst_busy1", {63'd0, bus.busy1}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd3, 5'd3);
        #1;
        chk("post_rst_rd3", bus.rdata1, 64'd0);
        chk("post_rst_busy3", {63'd0, bus.busy1}, 64'd0);
        cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd3, 5'd3);

        // Fill with random contents, then reset and scan every address
        for (int a = 0; a < 32; a++)
            cycle(1'b1, 5'(a), {$urandom, $urandom}, 1'($urandom), 5'(a), 5'(a), 5'(a));
        reset = 1'b1;
        model_clear();
        for (int a = 0; a < 32; a++)
            cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'(a), 5'(31 - a));
        reset = 1'b0;
        cycle(1'b1, 5'd4, 64'hA5A5, 1'b0, 5'd0, 5'd4, 5'd4);
        cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd4, 5'd6);
        chk("first_wr_after_rst", bus.rdata1, 64'hA5A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
